axi_mem_tester: RTL
===================

Name: axi_mem_tester

Overview:
- AXI4 memory-mapped master that exercises any AXI slave with the same reduced signal set used by axi_bram.
- Writes a deterministic pattern over a region in INCR bursts, reads the region back, compares, and reports pass/fail and error details.
- Sits on the slave side of an AXI interconnect, or directly on an axi_bram instance, for bring-up and self-test without host DMA.

Parameters:
- AXI_IDWIDTH, 4, ID width; all transactions use ID 0.
- AXI_AWIDTH, 64, address width.
- AXI_DWIDTH, 64, data width; must be a multiple of 32.
- BURST_LEN, 16, beats per burst, 1..256. BURST_LEN*AXI_DWIDTH/8 must be ≤ 4096.
- NUM_BURSTS, 64, bursts per pass, ≥ 1.
- BASE_ADDR, 0, start byte address; aligned to BURST_LEN*AXI_DWIDTH/8.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE or DONE.
- i_seed  in  32  pattern seed; latched on accepted start.
- o_busy  out  1  high from accepted start until DONE.
- o_done  out  1  high in DONE, cleared by the next accepted start.
- o_pass  out  1  o_done && (o_err_cnt == 0).
- o_err_cnt  out  16  error count; saturates at 16'hFFFF.
- o_first_err_addr  out  AXI_AWIDTH  byte address of the first error.
- AXI master write-address channel: m_axi_awready in 1; m_axi_awvalid out 1; m_axi_awaddr out AXI_AWIDTH; m_axi_awlen out 8; m_axi_awid out AXI_IDWIDTH.
- AXI master write-data channel: m_axi_wready in 1; m_axi_wvalid out 1; m_axi_wlast out 1; m_axi_wdata out AXI_DWIDTH; m_axi_wstrb out AXI_DWIDTH/8.
- AXI master write-response channel: m_axi_bready out 1; m_axi_bvalid in 1; m_axi_bid in AXI_IDWIDTH; m_axi_bresp in 2.
- AXI master read-address channel: m_axi_arready in 1; m_axi_arvalid out 1; m_axi_araddr out AXI_AWIDTH; m_axi_arlen out 8; m_axi_arid out AXI_IDWIDTH.
- AXI master read-data channel: m_axi_rready out 1; m_axi_rvalid in 1; m_axi_rlast in 1; m_axi_rdata in AXI_DWIDTH; m_axi_rid in AXI_IDWIDTH; m_axi_rresp in 2.

Behaviour:
- Reset (asynchronous, rstn low) forces, immediately:
  - all valid and ready outputs to 0;
  - o_busy, o_done, o_pass, o_err_cnt, o_first_err_addr, all addresses and counters to 0;
  - state to IDLE.
- Reset mid-transaction abandons the transaction; no completion is attempted.
- Constant outputs:
  - awid = arid = 0.
  - awlen = arlen = BURST_LEN-1.
  - wstrb all ones.
- Pattern: the beat at byte address A carries data = zero-extended word index W = (A-BASE_ADDR)/(AXI_DWIDTH/8), XOR i_seed replicated AXI_DWIDTH/32 times.
- Burst k address = BASE_ADDR + k*BURST_LEN*AXI_DWIDTH/8, for k = 0..NUM_BURSTS-1.
- One transaction outstanding at a time.
- FSM:
  - IDLE/DONE: on i_start, latch seed, clear errors and o_done, set k=0, go to WR_ADDR.
  - WR_ADDR: awvalid=1 with a stable address. On awready&&awvalid, go to WR_DATA with beat=0. W never precedes AW.
  - WR_DATA: wvalid=1; wdata and wlast are stable while stalled. wlast=1 when beat==BURST_LEN-1. Each handshake advances beat; the last handshake goes to WR_RESP.
  - WR_RESP: bready=1. On bvalid: an error if bresp!=0 or bid!=0. Then k++; go to WR_ADDR, or RD_ADDR with k=0 after the last burst.
  - RD_ADDR: arvalid=1. On arready, go to RD_DATA with beat=0.
  - RD_DATA: rready=1. Each rvalid beat is compared. Error conditions, one count per beat maximum:
    - rdata != expected;
    - rresp != 0;
    - rid != 0;
    - rlast != (beat==BURST_LEN-1).
  - RD_DATA exit: the beat with beat==BURST_LEN-1 ends the burst regardless of rlast; then k++; go to RD_ADDR, or DONE after the last burst.
  - DONE: o_done=1, o_busy=0.
- Error counting:
  - Each write-response error counts 1, at the burst base address.
  - o_first_err_addr is captured only when o_err_cnt transitions from 0.
  - o_err_cnt saturates at 16'hFFFF.
- i_start while busy is ignored.
- Valid is never deasserted before its handshake (AXI rule); outputs are registered.

Test Plan:
- Ideal slave (ready always 1, 1-cycle read latency), seed 0, BURST_LEN 16, NUM_BURSTS 4 -> 4 AW at 0x0/0x80/0x100/0x180 with wdata 0..63; 4 AR; o_done=1, o_pass=1, o_err_cnt=0.
- axi_bram with random awready/wready/arready/rvalid backpressure, seed 32'hA5A5A5A5 -> AXI protocol checker clean (stable payload under stall); o_pass=1.
- Slave corrupts rdata bit 0 at word index 37 -> o_err_cnt=1, o_first_err_addr=0x128, o_pass=0.
- Slave returns bresp=2'b10 for burst 2 -> o_err_cnt≥1, o_first_err_addr=0x100.
- Slave asserts rlast one beat early in burst 0 -> error counted; FSM still consumes 16 beats and proceeds to burst 1.
- rstn low during WR_DATA beat 5 -> all valids 0 in the same cycle; after release, IDLE; i_start during a run is ignored; a new i_start completes with o_pass=1.

Source files
------------

// File: rtl/axi_mem_tester_if.sv
// AXI4 master bundle (reduced signal set) between axi_mem_tester and a memory slave.
// The master modport is the tester side; the slave modport is the memory side.
interface axi_mem_tester_if #(
  parameter int unsigned AXI_IDWIDTH = 4,
  parameter int unsigned AXI_AWIDTH  = 64,
  parameter int unsigned AXI_DWIDTH  = 64
);
  logic                    awready;
  logic                    awvalid;
  logic [AXI_AWIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [AXI_IDWIDTH-1:0]  awid;

  logic                    wready;
  logic                    wvalid;
  logic                    wlast;
  logic [AXI_DWIDTH-1:0]   wdata;
  logic [AXI_DWIDTH/8-1:0] wstrb;

  logic                    bready;
  logic                    bvalid;
  logic [AXI_IDWIDTH-1:0]  bid;
  logic [1:0]              bresp;

  logic                    arready;
  logic                    arvalid;
  logic [AXI_AWIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [AXI_IDWIDTH-1:0]  arid;

  logic                    rready;
  logic                    rvalid;
  logic                    rlast;
  logic [AXI_DWIDTH-1:0]   rdata;
  logic [AXI_IDWIDTH-1:0]  rid;
  logic [1:0]              rresp;

  modport master (
    input  awready, output awvalid, awaddr, awlen, awid,
    input  wready,  output wvalid, wlast, wdata, wstrb,
    output bready,  input  bvalid, bid, bresp,
    input  arready, output arvalid, araddr, arlen, arid,
    output rready,  input  rvalid, rlast, rdata, rid, rresp
  );

  modport slave (
    output awready, input  awvalid, awaddr, awlen, awid,
    output wready,  input  wvalid, wlast, wdata, wstrb,
    input  bready,  output bvalid, bid, bresp,
    output arready, input  arvalid, araddr, arlen, arid,
    input  rready,  output rvalid, rlast, rdata, rid, rresp
  );
endinterface

// File: rtl/axi_mem_tester.sv
// AXI4 memory self-test master: writes a seeded word-index pattern in INCR bursts over a region,
// reads it back, and reports error count and the byte address of the first error.
module axi_mem_tester #(
  parameter int unsigned           AXI_IDWIDTH = 4,
  parameter int unsigned           AXI_AWIDTH  = 64,
  parameter int unsigned           AXI_DWIDTH  = 64,
  parameter int unsigned           BURST_LEN   = 16,
  parameter int unsigned           NUM_BURSTS  = 64,
  parameter logic [AXI_AWIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_start,
  input  logic [31:0]           i_seed,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [15:0]           o_err_cnt,
  output logic [AXI_AWIDTH-1:0] o_first_err_addr,
  axi_mem_tester_if.master      m_axi
);

  localparam int unsigned BEAT_BYTES  = AXI_DWIDTH / 8;
  localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int unsigned NREP        = AXI_DWIDTH / 32;
  localparam int unsigned KW          = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [7:0]    LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [KW-1:0] LAST_K    = KW'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData, StDone
  } state_e;

  state_e r_state, w_state_d;

  logic [31:0]           r_seed;
  logic [KW-1:0]         r_k;
  logic [7:0]            r_beat;
  logic [31:0]           r_word;
  logic [AXI_AWIDTH-1:0] r_addr;
  logic [15:0]           r_err_cnt;
  logic [AXI_AWIDTH-1:0] r_first_err_addr;

  logic r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready, r_busy, r_done;
  logic w_awvalid_d, w_wvalid_d, w_bready_d, w_arvalid_d, w_rready_d, w_busy_d, w_done_d;

  logic                  w_start;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic                  w_last_beat, w_last_k, w_burst_end;
  logic [AXI_DWIDTH-1:0] w_pattern;
  logic                  w_b_err, w_r_err, w_err;
  logic [AXI_AWIDTH-1:0] w_err_addr;

  assign w_start     = i_start && (r_state == StIdle || r_state == StDone);
  assign w_aw_hs     = r_awvalid && m_axi.awready;
  assign w_w_hs      = r_wvalid && m_axi.wready;
  assign w_b_hs      = r_bready && m_axi.bvalid;
  assign w_ar_hs     = r_arvalid && m_axi.arready;
  assign w_r_hs      = r_rready && m_axi.rvalid;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_last_k    = (r_k == LAST_K);
  assign w_burst_end = w_b_hs || (w_r_hs && w_last_beat);

  // r_word is the running word index, so the pattern is a pure function of registers.
  assign w_pattern = {NREP{r_seed}} ^ AXI_DWIDTH'(r_word);

  assign w_b_err = w_b_hs && (m_axi.bresp != 2'b00 || m_axi.bid != '0);
  assign w_r_err = w_r_hs && (m_axi.rdata != w_pattern || m_axi.rresp != 2'b00 ||
                              m_axi.rid != '0 || m_axi.rlast != w_last_beat);
  assign w_err   = w_b_err || w_r_err;
  assign w_err_addr = w_r_err ? r_addr + AXI_AWIDTH'(r_beat) * AXI_AWIDTH'(BEAT_BYTES) : r_addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_awvalid <= w_awvalid_d;
      r_wvalid  <= w_wvalid_d;
      r_bready  <= w_bready_d;
      r_arvalid <= w_arvalid_d;
      r_rready  <= w_rready_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: if (i_start) w_state_d = StWrAddr;
      StWrAddr:       if (w_aw_hs) w_state_d = StWrData;
      StWrData:       if (w_w_hs && w_last_beat) w_state_d = StWrResp;
      StWrResp:       if (w_b_hs) w_state_d = w_last_k ? StRdAddr : StWrAddr;
      StRdAddr:       if (w_ar_hs) w_state_d = StRdData;
      StRdData:       if (w_r_hs && w_last_beat) w_state_d = w_last_k ? StDone : StRdAddr;
      default:        w_state_d = StIdle;
    endcase
  end

  // Output flags are decoded from the next state and registered, so they change only on edges.
  always_comb begin
    w_awvalid_d = (w_state_d == StWrAddr);
    w_wvalid_d  = (w_state_d == StWrData);
    w_bready_d  = (w_state_d == StWrResp);
    w_arvalid_d = (w_state_d == StRdAddr);
    w_rready_d  = (w_state_d == StRdData);
    w_done_d    = (w_state_d == StDone);
    w_busy_d    = !(w_state_d == StIdle || w_state_d == StDone);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_seed           <= '0;
      r_k              <= '0;
      r_beat           <= '0;
      r_word           <= '0;
      r_addr           <= '0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else if (w_start) begin
      r_seed           <= i_seed;
      r_k              <= '0;
      r_beat           <= '0;
      r_word           <= '0;
      r_addr           <= BASE_ADDR;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
    end else begin
      if (w_aw_hs || w_ar_hs) r_beat <= '0;
      if (w_w_hs || w_r_hs) begin
        r_beat <= r_beat + 8'd1;
        r_word <= r_word + 32'd1;
      end
      if (w_burst_end) begin
        if (w_last_k) begin
          r_k    <= '0;
          r_addr <= BASE_ADDR;
          r_word <= '0;
        end else begin
          r_k    <= r_k + KW'(1);
          r_addr <= r_addr + AXI_AWIDTH'(BURST_BYTES);
        end
      end
      if (w_err) begin
        if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
        if (r_err_cnt == 16'd0) r_first_err_addr <= w_err_addr;
      end
    end
  end

  assign m_axi.awvalid = r_awvalid;
  assign m_axi.awaddr  = r_addr;
  assign m_axi.awlen   = LAST_BEAT;
  assign m_axi.awid    = '0;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.wlast   = w_last_beat;
  assign m_axi.wdata   = w_pattern;
  assign m_axi.wstrb   = '1;
  assign m_axi.bready  = r_bready;
  assign m_axi.arvalid = r_arvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = LAST_BEAT;
  assign m_axi.arid    = '0;
  assign m_axi.rready  = r_rready;

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_done && (r_err_cnt == 16'd0);
  assign o_err_cnt        = r_err_cnt;
  assign o_first_err_addr = r_first_err_addr;

endmodule
